opc5_mem_arbiter: RTL and testbench
===================================

Name: opc5_mem_arbiter

Overview:
Two-port arbiter sharing one single-port synchronous 16-bit memory between the OPC5 CPU bus master (port 0) and a secondary master such as DMA or video fetch (port 1). It decides the owner each cycle and muxes address, write data and rnw onto the memory. It returns read data with a one-cycle valid strobe. Starvation of port 1 is bounded by a wait counter; a lock input supports back-to-back read-modify-write sequences.

Parameters:
AW, 16, address width
DW, 16, data width
POLICY, 0, 0 = fixed priority to port 0 with anti-starvation; 1 = round-robin
MAX_WAIT, 4, cycles port 1 may be refused before forced grant (POLICY=0 only); range 1..15

Ports:
clk  in  1  system clock, all state on rising edge
reset_b  in  1  asynchronous active-low reset
req0/req1  in  1  access request; held with addr/wdata/rnw stable until gnt seen
rnw0/rnw1  in  1  1 = read, 0 = write
addr0/addr1  in  AW  word address
wdata0/wdata1  in  DW  write data
lock0/lock1  in  1  keep ownership for next cycle while asserted with req
gnt0/gnt1  out  1  access issued this cycle (combinational from current req and registered state)
rvalid0/rvalid1  out  1  registered pulse: rdata valid for a read granted last cycle
rdata  out  DW  memory read data, shared by both ports
mem_ce  out  1  memory access enable
mem_rnw  out  1  memory read/not-write
mem_address  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid one cycle after a read

Behaviour:
- One access per cycle, fully pipelined. Grant in cycle N drives mem_ce=1 with the owner's addr/rnw/wdata in cycle N. For reads, rvalidX=1 and rdata=mem_rdata in cycle N+1.
- Never both gnt0 and gnt1 asserted. When no grant: mem_ce=0, mem_rnw=1, mem_address/mem_wdata hold the port 0 values (don't-care to memory).
- Registered state: last_owner (1 bit), wait_cnt (4 bits), lock_owner valid and id, rvalid0/1.
- Decision order:
  1. If lock is active and the locked port still requests, grant it.
  2. If only one port requests, grant it.
  3. If both request under POLICY=1, grant the port that is not last_owner.
  4. If both request under POLICY=0, grant port 0 unless wait_cnt >= MAX_WAIT; in that case grant port 1.
- wait_cnt (POLICY=0): increments, saturating at 15, each cycle req1=1 and gnt1=0. Clears on gnt1 or when req1=0.
- Lock: set when gntX and lockX are both 1. Cleared the first cycle the locked port drops lockX or reqX. A lock overrides the anti-starvation rule; wait_cnt keeps counting while locked.
- last_owner updates on every grant.
- A request withdrawn without a grant is legal and leaves no residue.
- Reset (asynchronous, any cycle including mid-access):
  - gnt0/1=0, rvalid0/1=0, mem_ce=0, mem_rnw=1.
  - last_owner=1, so port 0 wins the first round-robin tie.
  - wait_cnt=0, lock cleared.
  - A read in flight at reset produces no rvalid.
- Writes produce no rvalid. A write granted in cycle N followed by a read of the same address in N+1 returns the new data (memory write-first not required: the read is issued after the write completes).

Decomposition:
- Shared package opc5_bus_pkg holds the port index constants (PORT_CPU=0, PORT_AUX=1), the POLICY encodings (POL_FIXED, POL_RR) and the default widths. Other OPC5 bus blocks reuse these.
- One natural sub-module: opc5_arb_pick, a purely combinational decision function taking reqs, lock state, last_owner and wait_cnt and returning the grant vector. It is unit-testable on its own; the top holds the registers and the datapath mux.

Test Plan:
- Reset then req0 read addr 0x0010, memory returns 0x1234 -> gnt0 in cycle 1, rvalid0=1 and rdata=0x1234 in cycle 2, gnt1/rvalid1 stay 0.
- POLICY=0, MAX_WAIT=4, req0 and req1 held high continuously -> gnt0 for 4 cycles, gnt1 on the 5th, then the pattern repeats (1 of every 5 cycles to port 1).
- POLICY=1, both requesting continuously from reset -> grants alternate 0,1,0,1; a solitary req1 is granted every cycle.
- Port 1 lock1=1 with a read of 0x0200 then a write of 0x0200 while req0 is held -> gnt1 on two consecutive cycles, gnt0 only after lock1 drops, even with wait_cnt irrelevant.
- Write 0xBEEF to 0x0005 by port 0 then read 0x0005 by port 1 in the next cycle -> rvalid1 with rdata=0xBEEF, and no rvalid0 for the write.
- Assert reset_b=0 in the cycle after a granted read -> rvalid stays 0, mem_ce=0 immediately; after release the first round-robin tie goes to port 0.

Source files
------------

// File: rtl/opc5_bus_pkg.sv
// Shared OPC5 bus constants: port indices, arbitration policy encodings, default widths.
package opc5_bus_pkg;

    localparam int unsigned PORT_CPU  = 0;
    localparam int unsigned PORT_AUX  = 1;

    localparam int unsigned POL_FIXED = 0;
    localparam int unsigned POL_RR    = 1;

    localparam int unsigned DEF_AW    = 16;
    localparam int unsigned DEF_DW    = 16;

    localparam int unsigned WAIT_W    = 4;
    localparam int unsigned WAIT_SAT  = 15;

    // Registered lock ownership: valid flag plus the port index holding it.
    typedef struct packed {
        logic valid;
        logic id;
    } lock_t;

endpackage

// File: rtl/opc5_mem_arbiter_if.sv
// Two-master shared-memory bus: request side of both ports plus the memory side.
interface opc5_mem_arbiter_if #(
    parameter int unsigned AW = opc5_bus_pkg::DEF_AW,
    parameter int unsigned DW = opc5_bus_pkg::DEF_DW
);
    logic          req0;
    logic          req1;
    logic          rnw0;
    logic          rnw1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          lock0;
    logic          lock1;
    logic          gnt0;
    logic          gnt1;
    logic          rvalid0;
    logic          rvalid1;
    logic [DW-1:0] rdata;
    logic          mem_ce;
    logic          mem_rnw;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req0, req1, rnw0, rnw1, addr0, addr1, wdata0, wdata1, lock0, lock1,
        input  mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata,
        output mem_ce, mem_rnw, mem_address, mem_wdata
    );

    modport master (
        output req0, req1, rnw0, rnw1, addr0, addr1, wdata0, wdata1, lock0, lock1,
        output mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata,
        input  mem_ce, mem_rnw, mem_address, mem_wdata
    );

endinterface

// File: rtl/opc5_arb_pick.sv
// Combinational grant decision: lock, single requester, then policy tie-break.
module opc5_arb_pick
    import opc5_bus_pkg::*;
#(
    parameter int unsigned POLICY   = POL_FIXED,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic [1:0]        req_i,
    input  lock_t             lock_i,
    input  logic              last_owner_i,
    input  logic [WAIT_W-1:0] wait_cnt_i,
    output logic [1:0]        gnt_c_o
);

    always_comb begin
        gnt_c_o = 2'b00;
        if (lock_i.valid && req_i[lock_i.id]) begin
            gnt_c_o[lock_i.id] = 1'b1;
        end else begin
            unique case (req_i)
                2'b01:   gnt_c_o = 2'b01;
                2'b10:   gnt_c_o = 2'b10;
                2'b11: begin
                    if (POLICY == POL_RR) begin
                        gnt_c_o = last_owner_i ? 2'b01 : 2'b10;
                    end else begin
                        // Port 1 is forced through once it has waited long enough.
                        gnt_c_o = (wait_cnt_i >= WAIT_W'(MAX_WAIT)) ? 2'b10 : 2'b01;
                    end
                end
                default: gnt_c_o = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/opc5_mem_arbiter.sv
// Two-port arbiter for one single-port synchronous memory: grant, datapath mux, read-valid return.
module opc5_mem_arbiter
    import opc5_bus_pkg::*;
#(
    parameter int unsigned AW       = DEF_AW,
    parameter int unsigned DW       = DEF_DW,
    parameter int unsigned POLICY   = POL_FIXED,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic               clk,
    input  logic               reset_b,
    opc5_mem_arbiter_if.slave  bus
);

    logic              last_owner_q, last_owner_d;
    logic [WAIT_W-1:0] wait_cnt_q,   wait_cnt_d;
    lock_t             lock_q,       lock_d;
    logic [1:0]        rvalid_q,     rvalid_d;

    logic [1:0]        req;
    logic [1:0]        gnt_pick;
    logic [1:0]        gnt;

    assign req = {bus.req1, bus.req0};

    opc5_arb_pick #(
        .POLICY   (POLICY),
        .MAX_WAIT (MAX_WAIT)
    ) u_pick (
        .req_i        (req),
        .lock_i       (lock_q),
        .last_owner_i (last_owner_q),
        .wait_cnt_i   (wait_cnt_q),
        .gnt_c_o      (gnt_pick)
    );

    // No access may reach the memory while reset is held, even mid-cycle.
    assign gnt = gnt_pick & {2{reset_b}};

    always_comb begin
        last_owner_d = last_owner_q;
        wait_cnt_d   = '0;
        lock_d       = '0;
        rvalid_d     = 2'b00;

        if (|gnt) begin
            last_owner_d = gnt[1];
        end
        if (req[1] && !gnt[1]) begin
            wait_cnt_d = (wait_cnt_q == WAIT_W'(WAIT_SAT)) ? wait_cnt_q
                                                           : wait_cnt_q + WAIT_W'(1);
        end
        lock_d.valid = (gnt[0] && bus.lock0) || (gnt[1] && bus.lock1);
        lock_d.id    = gnt[1];
        rvalid_d     = {gnt[1] && bus.rnw1, gnt[0] && bus.rnw0};
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            last_owner_q <= 1'(PORT_AUX);
            wait_cnt_q   <= '0;
            lock_q       <= '0;
            rvalid_q     <= 2'b00;
        end else begin
            last_owner_q <= last_owner_d;
            wait_cnt_q   <= wait_cnt_d;
            lock_q       <= lock_d;
            rvalid_q     <= rvalid_d;
        end
    end

    assign bus.gnt0        = gnt[0];
    assign bus.gnt1        = gnt[1];
    assign bus.rvalid0     = rvalid_q[0];
    assign bus.rvalid1     = rvalid_q[1];
    assign bus.rdata       = bus.mem_rdata;

    // Idle bus parks on port 0 values with a read strobe.
    assign bus.mem_ce      = |gnt;
    assign bus.mem_rnw     = gnt[1] ? bus.rnw1 : (gnt[0] ? bus.rnw0 : 1'b1);
    assign bus.mem_address = gnt[1] ? bus.addr1  : bus.addr0;
    assign bus.mem_wdata   = gnt[1] ? bus.wdata1 : bus.wdata0;

endmodule

// File: tb/tb_opc5_mem_arbiter.sv
// Bench for opc5_mem_arbiter: fixed-priority and round-robin instances against a rule-level model.
module tb_opc5_mem_arbiter;

    logic clk;
    logic reset_b;
    logic mem_clr;

    logic        t_req0, t_req1, t_rnw0, t_rnw1, t_lock0, t_lock1;
    logic [15:0] t_addr0, t_addr1, t_wd0, t_wd1;

    int checks;
    int failures;

    opc5_mem_arbiter_if #(.AW(16), .DW(16)) if_f ();
    opc5_mem_arbiter_if #(.AW(16), .DW(16)) if_r ();

    opc5_mem_arbiter #(.AW(16), .DW(16), .POLICY(0), .MAX_WAIT(4)) u_fix (
        .clk(clk), .reset_b(reset_b), .bus(if_f.slave));
    opc5_mem_arbiter #(.AW(16), .DW(16), .POLICY(1), .MAX_WAIT(4)) u_rr (
        .clk(clk), .reset_b(reset_b), .bus(if_r.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign if_f.req0 = t_req0;   assign if_r.req0 = t_req0;
    assign if_f.req1 = t_req1;   assign if_r.req1 = t_req1;
    assign if_f.rnw0 = t_rnw0;   assign if_r.rnw0 = t_rnw0;
    assign if_f.rnw1 = t_rnw1;   assign if_r.rnw1 = t_rnw1;
    assign if_f.addr0 = t_addr0; assign if_r.addr0 = t_addr0;
    assign if_f.addr1 = t_addr1; assign if_r.addr1 = t_addr1;
    assign if_f.wdata0 = t_wd0;  assign if_r.wdata0 = t_wd0;
    assign if_f.wdata1 = t_wd1;  assign if_r.wdata1 = t_wd1;
    assign if_f.lock0 = t_lock0; assign if_r.lock0 = t_lock0;
    assign if_f.lock1 = t_lock1; assign if_r.lock1 = t_lock1;

    // Behavioural single-port memories: unwritten words read as index ^ 0x1224.
    logic [15:0] dmem_f [1024];
    logic [15:0] dmem_r [1024];
    logic        dval_f [1024];
    logic        dval_r [1024];
    logic [15:0] mrd_f, mrd_r;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) begin
                dval_f[i] <= 1'b0;
                dval_r[i] <= 1'b0;
            end
        end else begin
            if (if_f.mem_ce) begin
                if (if_f.mem_rnw)
                    mrd_f <= dval_f[if_f.mem_address[9:0]] ? dmem_f[if_f.mem_address[9:0]]
                                                           : (16'(if_f.mem_address[9:0]) ^ 16'h1224);
                else begin
                    dmem_f[if_f.mem_address[9:0]] <= if_f.mem_wdata;
                    dval_f[if_f.mem_address[9:0]] <= 1'b1;
                end
            end
            if (if_r.mem_ce) begin
                if (if_r.mem_rnw)
                    mrd_r <= dval_r[if_r.mem_address[9:0]] ? dmem_r[if_r.mem_address[9:0]]
                                                           : (16'(if_r.mem_address[9:0]) ^ 16'h1224);
                else begin
                    dmem_r[if_r.mem_address[9:0]] <= if_r.mem_wdata;
                    dval_r[if_r.mem_address[9:0]] <= 1'b1;
                end
            end
        end
    end

    assign if_f.mem_rdata = mrd_f;
    assign if_r.mem_rdata = mrd_r;

    logic [1:0]  gnt_f, gnt_r, rv_f, rv_r;
    logic        ce_f, ce_r, rnw_f, rnw_r;
    logic [15:0] adr_f, adr_r, wd_f, wd_r, rd_f, rd_r;

    assign gnt_f = {if_f.gnt1, if_f.gnt0};       assign gnt_r = {if_r.gnt1, if_r.gnt0};
    assign rv_f  = {if_f.rvalid1, if_f.rvalid0}; assign rv_r  = {if_r.rvalid1, if_r.rvalid0};
    assign ce_f  = if_f.mem_ce;                  assign ce_r  = if_r.mem_ce;
    assign rnw_f = if_f.mem_rnw;                 assign rnw_r = if_r.mem_rnw;
    assign adr_f = if_f.mem_address;             assign adr_r = if_r.mem_address;
    assign wd_f  = if_f.mem_wdata;               assign wd_r  = if_r.mem_wdata;
    assign rd_f  = if_f.rdata;                   assign rd_r  = if_r.rdata;

    // Reference state per instance (index 0 = fixed priority, 1 = round robin).
    logic        m_last [2];
    int          m_wait [2];
    logic        m_lv   [2];
    logic        m_lid  [2];
    logic [1:0]  m_rv   [2];
    logic [15:0] m_rd   [2];
    logic [15:0] mmem   [2][1024];
    logic [1:0]  obs_gnt [2];

    task automatic chk(input string tag, input int p, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s[p%0d] observed=%0h expected=%0h", tag, p, obs, exp);
        end
    endtask

    function automatic logic [1:0] pick_ref(input int pol, input logic r0, input logic r1,
                                            input logic lv, input logic lid, input logic last,
                                            input int w);
        if (lv && (lid ? r1 : r0)) return lid ? 2'b10 : 2'b01;
        if (!r0 && !r1) return 2'b00;
        if (r0 && !r1)  return 2'b01;
        if (r1 && !r0)  return 2'b10;
        if (pol == 1)   return last ? 2'b01 : 2'b10;
        return (w >= 4) ? 2'b10 : 2'b01;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_last[p] = 1'b1;
            m_wait[p] = 0;
            m_lv[p]   = 1'b0;
            m_lid[p]  = 1'b0;
            m_rv[p]   = 2'b00;
        end
    endtask

    // Check one cycle for both instances, advance the model, then move to the next cycle.
    task automatic step();
        logic [1:0]  g;
        logic        e_rnw;
        logic [15:0] e_adr, e_wd;
        #1;
        for (int p = 0; p < 2; p++) begin
            g     = pick_ref(p, t_req0, t_req1, m_lv[p], m_lid[p], m_last[p], m_wait[p]);
            e_rnw = g[1] ? t_rnw1 : (g[0] ? t_rnw0 : 1'b1);
            e_adr = g[1] ? t_addr1 : t_addr0;
            e_wd  = g[1] ? t_wd1 : t_wd0;
            obs_gnt[p] = (p == 1) ? gnt_r : gnt_f;
            chk("gnt",      p, 32'(obs_gnt[p]), 32'(g));
            chk("mem_ce",   p, 32'((p == 1) ? ce_r : ce_f), 32'(|g));
            chk("mem_rnw",  p, 32'((p == 1) ? rnw_r : rnw_f), 32'(e_rnw));
            chk("mem_addr", p, 32'((p == 1) ? adr_r : adr_f), 32'(e_adr));
            chk("mem_wd",   p, 32'((p == 1) ? wd_r : wd_f), 32'(e_wd));
            chk("rvalid",   p, 32'((p == 1) ? rv_r : rv_f), 32'(m_rv[p]));
            if (m_rv[p] != 2'b00)
                chk("rdata", p, 32'((p == 1) ? rd_r : rd_f), 32'(m_rd[p]));

            if (t_req1 && !g[1]) m_wait[p] = (m_wait[p] < 15) ? m_wait[p] + 1 : 15;
            else                 m_wait[p] = 0;
            if (g != 2'b00) m_last[p] = g[1];
            m_lv[p]  = (g[0] && t_lock0) || (g[1] && t_lock1);
            m_lid[p] = g[1];
            m_rv[p]  = {g[1] && t_rnw1, g[0] && t_rnw0};
            if (g != 2'b00) begin
                if (e_rnw) m_rd[p] = mmem[p][e_adr[9:0]];
                else       mmem[p][e_adr[9:0]] = e_wd;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Assert reset at the current point (inputs untouched), hold one edge, release.
    task automatic do_reset();
        reset_b = 1'b0;
        #1;
        for (int p = 0; p < 2; p++) begin
            chk("rst_gnt",    p, 32'((p == 1) ? gnt_r : gnt_f), 32'(0));
            chk("rst_ce",     p, 32'((p == 1) ? ce_r : ce_f), 32'(0));
            chk("rst_rnw",    p, 32'((p == 1) ? rnw_r : rnw_f), 32'(1));
            chk("rst_rvalid", p, 32'((p == 1) ? rv_r : rv_f), 32'(0));
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_hold_rvalid", 0, 32'(rv_f), 32'(0));
        chk("rst_hold_rvalid", 1, 32'(rv_r), 32'(0));
        reset_b = 1'b1;
    endtask

    task automatic idle_inputs();
        t_req0 = 0; t_req1 = 0; t_rnw0 = 1; t_rnw1 = 1; t_lock0 = 0; t_lock1 = 0;
        t_addr0 = '0; t_addr1 = '0; t_wd0 = '0; t_wd1 = '0;
    endtask

    initial begin
        int n1_f, n1_r;
        checks = 0; failures = 0;
        reset_b = 1'b0;
        mem_clr = 1'b1;
        idle_inputs();
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 1024; i++)
                mmem[p][i] = 16'(i) ^ 16'h1224;
        @(negedge clk);
        @(negedge clk);
        do_reset();
        mem_clr = 1'b0;

        // Single read by port 0, memory default word at 0x0010 is 0x1234.
        t_req0 = 1; t_rnw0 = 1; t_addr0 = 16'h0010;
        step();
        chk("first_gnt", 0, 32'(obs_gnt[0]), 32'(2'b01));
        idle_inputs();
        #1;
        chk("first_rvalid", 0, 32'(rv_f), 32'(2'b01));
        chk("first_rdata",  0, 32'(rd_f), 32'(16'h1234));
        chk("first_rvalid", 1, 32'(rv_r), 32'(2'b01));
        step();

        // Both ports hammering: fixed gives port 1 one slot in five, round robin alternates.
        do_reset();
        t_req0 = 1; t_req1 = 1; t_addr0 = 16'h0001; t_addr1 = 16'h0002;
        n1_f = 0; n1_r = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            n1_f += int'(obs_gnt[0][1]);
            n1_r += int'(obs_gnt[1][1]);
        end
        chk("fixed_gnt1_count", 0, 32'(n1_f), 32'(2));
        chk("rr_gnt1_count",    1, 32'(n1_r), 32'(5));
        t_req0 = 0;
        n1_r = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            n1_r += int'(obs_gnt[1][1]);
        end
        chk("solo_gnt1_count", 1, 32'(n1_r), 32'(3));
        idle_inputs();
        step();

        // Locked read-modify-write by port 1 while port 0 waits.
        do_reset();
        t_req1 = 1; t_lock1 = 1; t_rnw1 = 1; t_addr1 = 16'h0200;
        step();
        chk("lock_c1", 0, 32'(obs_gnt[0]), 32'(2'b10));
        t_req0 = 1; t_rnw0 = 1; t_addr0 = 16'h0030;
        t_rnw1 = 0; t_wd1 = 16'hA5A5;
        step();
        chk("lock_c2", 0, 32'(obs_gnt[0]), 32'(2'b10));
        chk("lock_c2", 1, 32'(obs_gnt[1]), 32'(2'b10));
        t_req1 = 0; t_lock1 = 0;
        step();
        chk("lock_c3", 0, 32'(obs_gnt[0]), 32'(2'b01));
        idle_inputs();
        step();

        // Write then read-after-write across ports.
        t_req0 = 1; t_rnw0 = 0; t_addr0 = 16'h0005; t_wd0 = 16'hBEEF;
        step();
        idle_inputs();
        t_req1 = 1; t_rnw1 = 1; t_addr1 = 16'h0005;
        step();
        idle_inputs();
        #1;
        chk("raw_rvalid", 0, 32'(rv_f), 32'(2'b10));
        chk("raw_rdata",  0, 32'(rd_f), 32'(16'hBEEF));
        step();

        // Reset right after a granted read: the read never reports valid.
        t_req0 = 1; t_rnw0 = 1; t_addr0 = 16'h0010;
        step();
        do_reset();
        t_req1 = 1;
        step();
        chk("post_rst_tie", 1, 32'(obs_gnt[1]), 32'(2'b01));
        idle_inputs();
        step();

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            t_req0  = ($urandom_range(0, 3) != 0);
            t_req1  = ($urandom_range(0, 3) != 0);
            t_rnw0  = 1'($urandom_range(0, 1));
            t_rnw1  = 1'($urandom_range(0, 1));
            t_lock0 = ($urandom_range(0, 7) == 0);
            t_lock1 = ($urandom_range(0, 7) == 0);
            t_addr0 = 16'($urandom_range(0, 15));
            t_addr1 = 16'($urandom_range(0, 15));
            t_wd0   = 16'($urandom);
            t_wd1   = 16'($urandom);
            if ($urandom_range(0, 99) == 0) do_reset();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
